// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch controller: one-outstanding imem request feeding a
// small {pc, instr} queue, with decode redirects and stale-response discard.
module fetch_queue_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_decode,
  input  logic             pcsrc_decode,
  input  logic [WIDTH-1:0] pc_jump,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic             stall_decode,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] pc_fetch,
  output logic [WIDTH-1:0] instr_fetch,
  output logic             instr_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, READY, BUSY, DISCARD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] pc_mem [DEPTH];
  logic [WIDTH-1:0] ins_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             fetching;
  logic             held;
  logic             push;
  logic             pop;
  logic             flush;

  always_comb begin
    redirect = jump_decode | pcsrc_decode;
    target   = jump_decode ? pc_jump : pc_branch;
    held     = (state == BUSY) || (state == DISCARD);
    fetching = (state == READY) && (count < FULL) && !redirect;
    push     = imem_ack && !redirect
             && (fetching || (state == BUSY));
    flush    = redirect && (state != IDLE);
    pop      = (count != '0) && !stall_decode && !redirect;
  end

  assign imem_req    = fetching || held;
  assign imem_addr   = held ? addr_q : pc_q;
  assign instr_valid = (count != '0);
  assign pc_fetch    = instr_valid ? pc_mem[rd_ptr] : '0;
  assign instr_fetch = instr_valid ? ins_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: state <= READY;
        READY: begin
          if (redirect) begin
            pc_q <= target;
          end else if (fetching) begin
            if (imem_ack) begin
              pc_q <= pc_q + WIDTH'(4);
            end else begin
              addr_q <= pc_q;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (redirect) begin
            pc_q  <= target;
            state <= imem_ack ? READY : DISCARD;
          end else if (imem_ack) begin
            pc_q  <= pc_q + WIDTH'(4);
            state <= READY;
          end
        end
        DISCARD: begin
          if (redirect) pc_q <= target;
          if (imem_ack) state <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]  <= imem_addr;
        ins_mem[wr_ptr] <= imem_rdata;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl: zero-wait and multi-cycle memory,
// stalls, redirects, discard and asynchronous reset.
module tb_fetch_queue_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_decode;
  logic        pcsrc_decode;
  logic [31:0] pc_jump;
  logic [31:0] pc_branch;
  logic        stall_decode;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_fetch;
  logic [31:0] instr_fetch;
  logic        instr_valid;

  logic zw;
  logic ack_man;
  int   n_tests;
  int   n_fail;

  assign imem_ack   = zw ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ 32'hDEAD0000;

  fetch_queue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .jump_decode  (jump_decode),
    .pcsrc_decode (pcsrc_decode),
    .pc_jump      (pc_jump),
    .pc_branch    (pc_branch),
    .stall_decode (stall_decode),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc_fetch     (pc_fetch),
    .instr_fetch  (instr_fetch),
    .instr_valid  (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    jump_decode = 1'b0;
    pcsrc_decode = 1'b0;
    pc_jump = '0;
    pc_branch = '0;
    stall_decode = 1'b0;
    zw = 1'b1;
    ack_man = 1'b0;
    #3;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_pc", pc_fetch, 0);
    chk("rst_instr", instr_fetch, 0);

    cyc(); rst = 1'b1; #1;
    chk("idle_req", 32'(imem_req), 0);
    cyc(); #1;
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_valid", 32'(instr_valid), 0);
    cyc(); #1;
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_valid", 32'(instr_valid), 1);
    chk("f1_pc", pc_fetch, 32'h0);
    chk("f1_instr", instr_fetch, 32'hDEAD0000);
    cyc(); #1;
    chk("f2_addr", imem_addr, 32'h8);
    chk("f2_pc", pc_fetch, 32'h4);

    cyc(); stall_decode = 1'b1; #1;
    chk("st0_addr", imem_addr, 32'hC);
    chk("st0_pc", pc_fetch, 32'h8);
    cyc(); #1;
    chk("st1_req", 32'(imem_req), 0);
    chk("st1_pc", pc_fetch, 32'h8);
    cyc(); #1;
    chk("st2_req", 32'(imem_req), 0);
    chk("st2_pc", pc_fetch, 32'h8);
    cyc(); stall_decode = 1'b0; #1;
    chk("rel0_pc", pc_fetch, 32'h8);
    chk("rel0_req", 32'(imem_req), 0);
    cyc(); #1;
    chk("rel1_pc", pc_fetch, 32'hC);
    chk("rel1_addr", imem_addr, 32'h10);
    cyc(); #1;
    chk("rel2_pc", pc_fetch, 32'h10);
    chk("rel2_instr", instr_fetch, 32'hDEAD0010);

    pcsrc_decode = 1'b1; pc_branch = 32'h20; #1;
    chk("br_req", 32'(imem_req), 0);
    cyc(); pcsrc_decode = 1'b0; #1;
    chk("br_valid", 32'(instr_valid), 0);
    chk("br_addr", imem_addr, 32'h20);
    cyc(); #1;
    chk("br_pc", pc_fetch, 32'h20);

    jump_decode = 1'b1; pcsrc_decode = 1'b1;
    pc_jump = 32'h80; pc_branch = 32'h20; #1;
    cyc(); jump_decode = 1'b0; pcsrc_decode = 1'b0; #1;
    chk("pri_addr", imem_addr, 32'h80);
    chk("pri_valid", 32'(instr_valid), 0);

    cyc(); zw = 1'b0; stall_decode = 1'b1; #1;
    chk("pre_pc", pc_fetch, 32'h80);
    chk("pre_addr", imem_addr, 32'h84);
    cyc(); #1;
    chk("bz_req", 32'(imem_req), 1);
    chk("bz_addr", imem_addr, 32'h84);
    #2; rst = 1'b0; ack_man = 1'b1; #1;
    chk("ar_req", 32'(imem_req), 0);
    chk("ar_valid", 32'(instr_valid), 0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_pc", pc_fetch, 32'h0);
    cyc(); #1;
    cyc(); rst = 1'b1; #1;
    chk("ar_idle_req", 32'(imem_req), 0);
    cyc(); ack_man = 1'b0; stall_decode = 1'b0; #1;
    chk("r1_addr", imem_addr, 32'h0);
    chk("r1_req", 32'(imem_req), 1);
    chk("r1_valid", 32'(instr_valid), 0);
    cyc(); #1;
    chk("r2_addr", imem_addr, 32'h0);
    cyc(); ack_man = 1'b1; #1;
    chk("r3_addr", imem_addr, 32'h0);
    cyc(); ack_man = 1'b0; #1;
    chk("r4_pc", pc_fetch, 32'h0);
    chk("r4_addr", imem_addr, 32'h4);
    cyc(); jump_decode = 1'b1; pc_jump = 32'h80; #1;
    chk("r5_req", 32'(imem_req), 1);
    chk("r5_addr", imem_addr, 32'h4);
    cyc(); jump_decode = 1'b0; #1;
    chk("dis_addr", imem_addr, 32'h4);
    chk("dis_req", 32'(imem_req), 1);
    chk("dis_valid", 32'(instr_valid), 0);
    cyc(); ack_man = 1'b1; #1;
    chk("dis2_addr", imem_addr, 32'h4);
    cyc(); ack_man = 1'b0; #1;
    chk("post_addr", imem_addr, 32'h80);
    chk("post_valid", 32'(instr_valid), 0);
    chk("post_req", 32'(imem_req), 1);

    zw = 1'b1;
    cyc(); jump_decode = 1'b1; pc_jump = 32'hFFFFFFFC; #1;
    chk("wj_pc", pc_fetch, 32'h80);
    chk("wj_req", 32'(imem_req), 0);
    cyc(); jump_decode = 1'b0; #1;
    chk("wrap0_addr", imem_addr, 32'hFFFFFFFC);
    cyc(); #1;
    chk("wrap1_addr", imem_addr, 32'h0);
    chk("wrap1_pc", pc_fetch, 32'hFFFFFFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_ctrl.md
FETCH_QUEUE_CTRL -- requirements
Module: fetch_queue_ctrl

Interface
REQ-001 Parameter WIDTH, default 32 (`WIDTH), address/instruction width.
REQ-002 Parameter DEPTH, default 2, instruction queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 jump_decode  input  1  jump redirect from decode.
REQ-007 pcsrc_decode  input  1  taken-branch redirect from decode.
REQ-008 pc_jump  input  WIDTH  jump target.
REQ-009 pc_branch  input  WIDTH  branch target.
REQ-010 stall_decode  input  1  decode cannot accept the head instruction this cycle.
REQ-011 imem_req  output  1  instruction memory request.
REQ-012 imem_addr  output  WIDTH  request address.
REQ-013 imem_ack  input  1  one-cycle response strobe; may arrive in the same cycle as imem_req.
REQ-014 imem_rdata  input  WIDTH  instruction word, valid when imem_ack=1.
REQ-015 pc_fetch  output  WIDTH  PC of queue head.
REQ-016 instr_fetch  output  WIDTH  instruction at queue head.
REQ-017 instr_valid  output  1  queue not empty.

Function
REQ-018 The block SHALL hold a fetch PC register, a DEPTH-entry FIFO of {pc, instr}, an occupancy count (0..DEPTH) and a state machine IDLE/READY/BUSY/DISCARD.
REQ-019 redirect = jump_decode|pcsrc_decode; target = pc_jump if jump_decode=1, else pc_branch (jump has priority).
REQ-020 IDLE: imem_req=0, redirect ignored; next state READY unconditionally.
REQ-021 READY: imem_req=1 combinationally when count<DEPTH and redirect=0; imem_addr=fetch PC.
REQ-022 READY with imem_req=1: ack in same cycle -> push {PC, rdata}, PC+=4, stay READY; no ack -> latch request address, go BUSY.
REQ-023 BUSY: imem_req=1, imem_addr=latched address; on ack push, PC+=4, go READY.
REQ-024 Once asserted, imem_req SHALL stay high with imem_addr stable until imem_ack (at most one outstanding request).
REQ-025 imem_ack when imem_req=0 SHALL be ignored.
REQ-026 Redirect in READY: PC<=target, FIFO cleared, count<=0, no request issued that cycle.
REQ-027 Redirect in BUSY: PC<=target, FIFO cleared; ack same cycle -> data dropped, go READY; otherwise go DISCARD.
REQ-028 DISCARD: imem_req=1 with stale address held; ack data dropped, go READY; further redirect updates PC, stays DISCARD, FIFO remains empty.
REQ-029 Pop when instr_valid=1 and stall_decode=0 and redirect=0; simultaneous push and pop leaves count unchanged.
REQ-030 Push never occurs with count=DEPTH (guaranteed by REQ-021).
REQ-031 pc_fetch/instr_fetch SHALL show the head entry and read 0 when count=0.
REQ-032 PC increment wraps modulo 2^WIDTH; target low bits used unmodified.
REQ-033 Zero-wait memory SHALL sustain one fetch per cycle with no bubbles when stall_decode=0.

Reset
REQ-034 rst=0 SHALL immediately force: state IDLE, PC=RESET_PC, count=0, FIFO storage 0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, pc_fetch=0, instr_fetch=0.
REQ-035 Reset asserted mid-request abandons it; an ack arriving during or after reset, before a new request, is ignored.

Verification
REQ-036 Release reset, zero-wait memory (ack=req) -> imem_addr 0x0,0x4,0x8 on consecutive cycles; instr_valid=1 from cycle after first ack, pc_fetch 0x0,0x4,0x8.
REQ-037 stall_decode=1 for 3 cycles, zero-wait -> count reaches 2, imem_req=0, head unchanged; on release every PC delivered exactly once in order.
REQ-038 pcsrc_decode=1, pc_branch=0x20 in READY -> next cycle instr_valid=0, imem_addr=0x20.
REQ-039 3-cycle memory, jump_decode=1, pc_jump=0x80 while BUSY at 0x4 -> DISCARD, imem_addr stays 0x4, stale data not enqueued, next request 0x80.
REQ-040 jump_decode=pcsrc_decode=1, pc_jump=0x80, pc_branch=0x20 -> next fetch 0x80.
REQ-041 rst=0 during BUSY -> imem_req=0 and instr_valid=0 without clock edge; after release, first fetch at RESET_PC.
